// File: rtl/sattn_cmd_dispatch.sv
// Sparse-attention command front-end: MMIO-fed command FIFO with in-order start/done dispatch to NUM_ENG engines.
// Define SATTN_DISPATCH_IRQ_EN to enable the IRQ_EN register and the level interrupt.
module sattn_cmd_dispatch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_ENG    = 4,
  parameter int CMDQ_DEPTH = 8,
  parameter int TMO_W      = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    mmio_wen,
  input  logic                    mmio_ren,
  input  logic [ADDR_WIDTH-1:0]   mmio_addr,
  input  logic [DATA_WIDTH-1:0]   mmio_wdata,
  output logic [DATA_WIDTH-1:0]   mmio_rdata,
  output logic [NUM_ENG-1:0]      eng_start,
  output logic [7:0]              eng_op,
  output logic [15:0]             eng_m_rows,
  output logic [15:0]             eng_head_d,
  output logic [15:0]             eng_s_tokens,
  input  logic [NUM_ENG-1:0]      eng_done,
  input  logic [NUM_ENG*64-1:0]   eng_sum,
  output logic                    busy,
  output logic                    done,
  output logic                    irq
);
  localparam int PW = $clog2(CMDQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  // Timeout fires on the (2**TMO_W-1)th WAIT cycle, when the counter holds 2**TMO_W-2.
  localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

  localparam logic [ADDR_WIDTH-1:0] A_MROWS  = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_HEADD  = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_STOK   = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_CMD    = ADDR_WIDTH'(8'h18);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h20);
  localparam logic [ADDR_WIDTH-1:0] A_LSUM   = ADDR_WIDTH'(8'h28);
  localparam logic [ADDR_WIDTH-1:0] A_RET    = ADDR_WIDTH'(8'h30);
  localparam logic [ADDR_WIDTH-1:0] A_IRQEN  = ADDR_WIDTH'(8'h38);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;
  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] m_rows;
    logic [15:0] head_d;
    logic [15:0] s_tokens;
  } cmd_t;

  state_t           state;
  cmd_t             q [CMDQ_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [15:0]      stg_m_rows, stg_head_d, stg_s_tokens;
  cmd_t             cur;
  logic [EW-1:0]    cur_idx;
  logic             cur_legal;
  logic [TMO_W-1:0] tmo_cnt;
  logic [63:0]      last_sum;
  logic [31:0]      retired;
  logic             done_stky, ovf, err, tmo, irq_en;

  logic wr_cmd, wr_stat, full, empty, pop, push, ovf_ev, done_ev, err_ev, tmo_ev, eng_hit;
  cmd_t             head;
  logic [7:0]       head_off;
  logic             head_legal;
  logic [EW-1:0]    head_idx;
  logic [63:0]      sel_sum;
  logic             unused_wdata;

  assign unused_wdata = ^mmio_wdata[DATA_WIDTH-1:16];
  assign wr_cmd  = mmio_wen && (mmio_addr == A_CMD);
  assign wr_stat = mmio_wen && (mmio_addr == A_STATUS);
  assign full    = (count == CW'(CMDQ_DEPTH));
  assign empty   = (count == '0);
  assign pop     = (state == S_IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a write to a full queue is still taken.
  assign push    = wr_cmd && (!full || pop);
  assign ovf_ev  = wr_cmd && full && !pop;

  assign head       = q[rd_ptr];
  assign head_off   = head.op - 8'h10;
  assign head_legal = (head.op >= 8'h10) && (head.op <= 8'h16);
  assign head_idx   = EW'(head_off % 8'(NUM_ENG));
  assign eng_hit    = eng_done[cur_idx];
  assign sel_sum    = eng_sum[int'(cur_idx)*64 +: 64];

  assign err_ev  = (state == S_ISSUE) && !cur_legal;
  assign tmo_ev  = (state == S_WAIT) && !eng_hit && (tmo_cnt == TMO_LAST);
  assign done_ev = err_ev || ((state == S_WAIT) && (eng_hit || (tmo_cnt == TMO_LAST)));

  assign busy         = (state != S_IDLE) || !empty;
  assign eng_op       = cur.op;
  assign eng_m_rows   = cur.m_rows;
  assign eng_head_d   = cur.head_d;
  assign eng_s_tokens = cur.s_tokens;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CMDQ_DEPTH; i++) q[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= {mmio_wdata[7:0], stg_m_rows, stg_head_d, stg_s_tokens};
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_m_rows   <= '0;
      stg_head_d   <= '0;
      stg_s_tokens <= '0;
    end else if (mmio_wen) begin
      if (mmio_addr == A_MROWS) stg_m_rows   <= mmio_wdata[15:0];
      if (mmio_addr == A_HEADD) stg_head_d   <= mmio_wdata[15:0];
      if (mmio_addr == A_STOK)  stg_s_tokens <= mmio_wdata[15:0];
    end
  end

  // Sticky status: a set event in the same cycle as the W1C wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_stky <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      tmo       <= 1'b0;
      retired   <= '0;
    end else begin
      done_stky <= done_ev | (done_stky & ~(wr_stat & mmio_wdata[0]));
      ovf       <= ovf_ev  | (ovf       & ~(wr_stat & mmio_wdata[4]));
      err       <= err_ev  | (err       & ~(wr_stat & mmio_wdata[5]));
      tmo       <= tmo_ev  | (tmo       & ~(wr_stat & mmio_wdata[6]));
      retired   <= retired + 32'(done_ev);
    end
  end

`ifdef SATTN_DISPATCH_IRQ_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (mmio_wen && (mmio_addr == A_IRQEN)) irq_en <= mmio_wdata[0];
      irq <= irq_en & (done_stky | ovf | err | tmo);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cur       <= '0;
      cur_idx   <= '0;
      cur_legal <= 1'b0;
      eng_start <= '0;
      tmo_cnt   <= '0;
      last_sum  <= '0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (pop) begin
          cur       <= head;
          cur_idx   <= head_idx;
          cur_legal <= head_legal;
          // start is launched with the pop so it is high throughout ISSUE
          eng_start <= head_legal ? (NUM_ENG'(1) << head_idx) : '0;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          eng_start <= '0;
          tmo_cnt   <= '0;
          if (err_ev) begin
            done  <= 1'b1;
            state <= S_RETIRE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_hit) begin
            last_sum <= sel_sum;
            done     <= 1'b1;
            state    <= S_RETIRE;
          end else if (tmo_ev) begin
            last_sum <= '0;
            done     <= 1'b1;
            state    <= S_RETIRE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RETIRE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (mmio_ren) begin
      case (mmio_addr)
        A_MROWS:  mmio_rdata = DATA_WIDTH'(stg_m_rows);
        A_HEADD:  mmio_rdata = DATA_WIDTH'(stg_head_d);
        A_STOK:   mmio_rdata = DATA_WIDTH'(stg_s_tokens);
        A_STATUS: mmio_rdata = DATA_WIDTH'({8'(count), 1'b0, tmo, err, ovf, empty, full, busy, done_stky});
        A_LSUM:   mmio_rdata = DATA_WIDTH'(last_sum);
        A_RET:    mmio_rdata = DATA_WIDTH'(retired);
        A_IRQEN:  mmio_rdata = DATA_WIDTH'(irq_en);
        default:  mmio_rdata = '0;
      endcase
    end
  end
endmodule
